// File: rtl/past_add_arbiter_if.sv
// Requester/result bus of the shared add pipeline.
// The master side drives operands and halt; the slave side is the arbiter.
interface past_add_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 8
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0][DW-1:0] req_a;
  logic [NUM_REQ-1:0][DW-1:0] req_b;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       halt;
  logic                       halted;
  logic                       res_valid;
  logic [DW-1:0]              res_data;
  logic [IDW-1:0]             res_id;
  logic                       busy;

  modport master (
    output req_valid, req_a, req_b, halt,
    input  req_ready, halted, res_valid, res_data, res_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, halt,
    output req_ready, halted, res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/past_add_arbiter.sv
// Round-robin arbiter sharing one LAT-stage modulo-2^DW adder among NUM_REQ requesters.
// Define PAST_ADD_ARB_FIXED_PRIO_EN for lowest-index-wins fixed priority.
module past_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 8,
  parameter int LAT     = 2
) (
  input  logic             clk,
  input  logic             rst,
  past_add_arbiter_if.slave bus
);
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STAGES = LAT - 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t                     state, state_nxt;
  logic                       gnt_en, halted_q;
  logic                       sel_found, accept;
  logic [IDW-1:0]             sel_id;
  logic [DW-1:0]              sum0;

  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0][DW-1:0]    stg_sum;
  logic [STAGES:0][IDW-1:0]   stg_id;
  logic [STAGES:0]            in_v;
  logic [STAGES:0][DW-1:0]    in_sum, nxt_sum;
  logic [STAGES:0][IDW-1:0]   in_id, nxt_id;
  logic                       busy;

  assign busy = |vld_pipe;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (bus.halt) state_nxt = DRAIN;
      DRAIN:   if (!bus.halt) state_nxt = RUN;
               else if (!busy) state_nxt = HALTED;
      HALTED:  if (!bus.halt) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // FSM: outputs; halt blocks grants in the very cycle it is seen
  always_comb begin
    gnt_en   = (state == RUN) && !bus.halt && !rst;
    halted_q = (state == HALTED);
  end

`ifdef PAST_ADD_ARB_FIXED_PRIO_EN
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!sel_found && bus.req_valid[IDW'(i)]) begin
        sel_found = 1'b1;
        sel_id    = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] cand;

  // scan from the pointer upward, wrapping at NUM_REQ
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = IDW'((int'(rr_ptr) + off) % NUM_REQ);
      if (!sel_found && bus.req_valid[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         rr_ptr <= '0;
    else if (accept) rr_ptr <= (sel_id == IDW'(NUM_REQ - 1)) ? '0 : sel_id + 1'b1;
  end
`endif

  assign accept        = gnt_en & sel_found;
  assign bus.req_ready = accept ? (NUM_REQ'(1) << sel_id) : '0;
  assign sum0          = bus.req_a[sel_id] + bus.req_b[sel_id];

  // stage s takes stage s-1; payload only moves with a valid op so the
  // output register holds its last result between pulses
  for (genvar s = 0; s <= STAGES; s++) begin : g_stg
    if (s == 0) begin : g_head
      assign in_v[s]   = accept;
      assign in_sum[s] = sum0;
      assign in_id[s]  = sel_id;
    end else begin : g_body
      assign in_v[s]   = vld_pipe[s-1];
      assign in_sum[s] = stg_sum[s-1];
      assign in_id[s]  = stg_id[s-1];
    end
    assign nxt_sum[s] = in_v[s] ? in_sum[s] : stg_sum[s];
    assign nxt_id[s]  = in_v[s] ? in_id[s]  : stg_id[s];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      stg_sum  <= '0;
      stg_id   <= '0;
    end else begin
      vld_pipe <= in_v;
      stg_sum  <= nxt_sum;
      stg_id   <= nxt_id;
    end
  end

  assign bus.res_valid = vld_pipe[STAGES];
  assign bus.res_data  = stg_sum[STAGES];
  assign bus.res_id    = stg_id[STAGES];
  assign bus.busy      = busy;
  assign bus.halted    = halted_q;
endmodule

// File: tb/tb_past_add_arbiter.sv
// Self-checking bench for past_add_arbiter: directed table, corner sequences,
// and a randomized run against a cycle-level reference model.
module tb_past_add_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  past_add_arbiter_if #(.NUM_REQ(NR), .DW(DW)) bus();

  past_add_arbiter #(.NUM_REQ(NR), .DW(DW), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.req_valid = '0;
    bus.halt      = 1'b0;
  endtask

  task automatic set_ops(input logic [7:0] a, input logic [7:0] b);
    for (int l = 0; l < NR; l++) begin
      bus.req_a[l] = a;
      bus.req_b[l] = b;
    end
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    idle_in();
    cyc();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [NR-1:0] v;
    logic [7:0]    a;
    logic [7:0]    b;
    logic [NR-1:0] rdy;
    logic [7:0]    sum;
    int            id;
  } vec_t;

  typedef struct {
    int         due;
    logic [7:0] sum;
    int         id;
  } op_t;

  vec_t tbl [8];

  // reference model state
  op_t        q[$];
  int         m_ptr, m_st;
  logic [7:0] l_sum;
  int         l_id;
  logic       pv [NR];
  logic [7:0] pa [NR];
  logic [7:0] pb [NR];

  initial begin
    logic [7:0] sa [NR];
    logic [7:0] sb [NR];
    logic [7:0] last;
    int nres, bf, hc, g;
    logic busy_e;

    // walked with the pointer starting at 0 after reset
    tbl[0] = '{4'b0100, 8'h10, 8'h25, 4'b0100, 8'h35, 2};
    tbl[1] = '{4'b1111, 8'hF0, 8'h20, 4'b1000, 8'h10, 3};
    tbl[2] = '{4'b0110, 8'hFF, 8'h01, 4'b0010, 8'h00, 1};
    tbl[3] = '{4'b0011, 8'h7F, 8'h01, 4'b0001, 8'h80, 0};
    tbl[4] = '{4'b0001, 8'h00, 8'h00, 4'b0001, 8'h00, 0};
    tbl[5] = '{4'b1100, 8'h12, 8'h34, 4'b0100, 8'h46, 2};
    tbl[6] = '{4'b0000, 8'h99, 8'h99, 4'b0000, 8'h00, 0};
    tbl[7] = '{4'b1001, 8'h55, 8'hAA, 4'b1000, 8'hFF, 3};

    idle_in();
    set_ops(8'h00, 8'h00);

    // reset state, and no grant while rst is high
    rst = 1'b1;
    bus.req_valid = '1;
    cyc();
    cyc();
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_id", bus.res_id, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_busy", bus.busy, 0);
    bus.req_valid = '0;
    cyc();
    rst = 1'b0;

`ifdef PAST_ADD_ARB_FIXED_PRIO_EN
    for (int c = 0; c < 8; c++) begin
      cyc();
      bus.req_valid = 4'b1010;
      #1;
      chk("fixed_ready", bus.req_ready, 4'b0010);
    end
    cyc();
    idle_in();
`else
    // directed table, one op at a time
    last = 8'h00;
    for (int i = 0; i < 8; i++) begin
      cyc();
      bus.req_valid = tbl[i].v;
      set_ops(tbl[i].a, tbl[i].b);
      #1;
      chk($sformatf("tbl%0d_ready", i), bus.req_ready, tbl[i].rdy);
      for (int k = 1; k <= LAT; k++) begin
        cyc();
        bus.req_valid = '0;
        #1;
        chk($sformatf("tbl%0d_vld_k%0d", i, k), bus.res_valid, (k == LAT) && (tbl[i].rdy != 0));
        chk($sformatf("tbl%0d_busy_k%0d", i, k), bus.busy, tbl[i].rdy != 0);
        if (k == LAT) begin
          if (tbl[i].rdy != 0) begin
            chk($sformatf("tbl%0d_data", i), bus.res_data, tbl[i].sum);
            chk($sformatf("tbl%0d_id", i), bus.res_id, tbl[i].id);
            last = tbl[i].sum;
          end else begin
            chk($sformatf("tbl%0d_hold", i), bus.res_data, last);
          end
        end
      end
      cyc();
      #1;
      chk($sformatf("tbl%0d_idle_busy", i), bus.busy, 0);
    end

    // all four requesters streaming
    do_reset();
    for (int l = 0; l < NR; l++) begin
      sa[l] = 8'(8'h11 * l + 8'h03);
      sb[l] = 8'(8'h40 + 8'h07 * l);
      bus.req_a[l] = sa[l];
      bus.req_b[l] = sb[l];
    end
    for (int c = 0; c < 8 + LAT; c++) begin
      cyc();
      bus.req_valid = (c < 8) ? '1 : '0;
      #1;
      if (c < 8) chk($sformatf("stream_ready%0d", c), bus.req_ready, 1 << (c % NR));
      if (c >= LAT) begin
        chk($sformatf("stream_vld%0d", c), bus.res_valid, 1);
        chk($sformatf("stream_id%0d", c), bus.res_id, (c - LAT) % NR);
        chk($sformatf("stream_data%0d", c), bus.res_data,
            (sa[(c - LAT) % NR] + sb[(c - LAT) % NR]) & 8'hFF);
      end else begin
        chk($sformatf("stream_vld%0d", c), bus.res_valid, 0);
      end
    end
    cyc();
    #1;
    chk("stream_tail", bus.res_valid, 0);

    // drain and resume
    do_reset();
    set_ops(8'h21, 8'h03);
    cyc();
    bus.req_valid = 4'b0001;
    #1;
    chk("drain_r0", bus.req_ready, 4'b0001);
    cyc();
    bus.req_valid = 4'b0010;
    #1;
    chk("drain_r1", bus.req_ready, 4'b0010);
    nres = 0; bf = -1; hc = -1;
    for (int c = 0; c < 12; c++) begin
      cyc();
      bus.req_valid = '1;
      bus.halt      = 1'b1;
      #1;
      chk($sformatf("drain_noGrant%0d", c), bus.req_ready, 0);
      if (bus.res_valid) begin
        chk($sformatf("drain_res_id%0d", nres), bus.res_id, nres);
        chk($sformatf("drain_res_data%0d", nres), bus.res_data, 8'h24);
        nres++;
      end
      if (!bus.busy && bf < 0) bf = c;
      if (bus.halted && hc < 0) hc = c;
    end
    chk("drain_nres", nres, 2);
    chk("drain_busy_fall", bf, 2);
    chk("drain_halted_at", hc, 3);
    cyc();
    bus.halt = 1'b0;
    #1;
    chk("resume_first_ready", bus.req_ready, 0);
    chk("resume_first_halted", bus.halted, 1);
    cyc();
    #1;
    chk("resume_ready", bus.req_ready, 4'b0100);
    chk("resume_halted", bus.halted, 0);
    cyc();
    idle_in();

    // reset with two ops in flight
    do_reset();
    set_ops(8'h44, 8'h11);
    cyc();
    bus.req_valid = 4'b0010;
    #1;
    chk("mrst_r1", bus.req_ready, 4'b0010);
    cyc();
    bus.req_valid = 4'b0100;
    #1;
    chk("mrst_r2", bus.req_ready, 4'b0100);
    cyc();
    bus.req_valid = '1;
    rst = 1'b1;
    #1;
    chk("mrst_ready_in_rst", bus.req_ready, 0);
    cyc();
    rst = 1'b0;
    bus.req_valid = '0;
    for (int k = 0; k <= LAT; k++) begin
      #1;
      chk($sformatf("mrst_vld%0d", k), bus.res_valid, 0);
      chk($sformatf("mrst_busy%0d", k), bus.busy, 0);
      chk($sformatf("mrst_data%0d", k), bus.res_data, 0);
      chk($sformatf("mrst_id%0d", k), bus.res_id, 0);
      cyc();
    end
    bus.req_valid = '1;
    #1;
    chk("mrst_ptr0", bus.req_ready, 4'b0001);
    cyc();
    idle_in();
`endif

    // randomized run against the reference model
    do_reset();
    m_ptr = 0; m_st = 0; l_sum = 8'h00; l_id = 0;
    q.delete();
    for (int l = 0; l < NR; l++) begin
      pv[l] = 1'b0; pa[l] = 8'h00; pb[l] = 8'h00;
    end
    for (int x = 0; x < 600; x++) begin
      cyc();
      for (int l = 0; l < NR; l++) begin
        if (!pv[l]) begin
          pv[l] = ($urandom_range(0, 99) < 55);
          pa[l] = 8'($urandom);
          pb[l] = 8'($urandom);
        end
        bus.req_valid[l] = pv[l];
        bus.req_a[l]     = pa[l];
        bus.req_b[l]     = pb[l];
      end
      if ($urandom_range(0, 99) < 6) bus.halt = ~bus.halt;
      #1;

      busy_e = (q.size() != 0);
      chk("rnd_busy", bus.busy, busy_e);
      chk("rnd_halted", bus.halted, m_st == 2);
      if (q.size() != 0 && q[0].due == x) begin
        chk("rnd_vld", bus.res_valid, 1);
        chk("rnd_data", bus.res_data, q[0].sum);
        chk("rnd_id", bus.res_id, q[0].id);
        l_sum = q[0].sum;
        l_id  = q[0].id;
        void'(q.pop_front());
      end else begin
        chk("rnd_vld", bus.res_valid, 0);
        chk("rnd_hold_data", bus.res_data, l_sum);
        chk("rnd_hold_id", bus.res_id, l_id);
      end

      g = -1;
      if (m_st == 0 && !bus.halt) begin
`ifdef PAST_ADD_ARB_FIXED_PRIO_EN
        for (int l = 0; l < NR; l++) if (g < 0 && pv[l]) g = l;
`else
        for (int off = 0; off < NR; off++)
          if (g < 0 && pv[(m_ptr + off) % NR]) g = (m_ptr + off) % NR;
`endif
      end
      chk("rnd_ready", bus.req_ready, (g >= 0) ? (1 << g) : 0);
      if (g >= 0) begin
        q.push_back('{x + LAT, 8'(pa[g] + pb[g]), g});
        m_ptr = (g + 1) % NR;
        pv[g] = 1'b0;
      end

      case (m_st)
        0: if (bus.halt) m_st = 1;
        1: if (!bus.halt) m_st = 0; else if (!busy_e) m_st = 2;
        default: if (!bus.halt) m_st = 0;
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
